// File: rtl/key_sched_ctrl.sv
// Iterative AES-128 key schedule: one roundKey step per cycle fills an 11-entry key store (10 cycles); registered 1-cycle read port.
// No backpressure: start is ignored while expanding. KEYSCHED_ZEROIZE_EN clears round keys on rekey and resets the store.
module key_sched_ctrl (
  input  logic         i_clk,
  input  logic         i_n_rst,
  input  logic         i_start,
  input  logic [127:0] i_key_in,
  output logic         o_busy,
  output logic         o_key_ready,
  output logic         o_done,
  input  logic         i_rd_en,
  input  logic [3:0]   i_rd_idx,
  output logic [127:0] o_rd_key,
  output logic         o_rd_valid,
  output logic         o_rd_err
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_accept;
  logic         w_step;
  logic         w_last;
  logic [127:0] w_next_key;
  logic [127:0] r_work;
  logic [3:0]   r_cnt;
  logic         r_done;
  logic [127:0] r_rd_key;
  logic         r_rd_valid;
  logic         r_rd_err;
  logic [127:0] r_store [0:10];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input logic [3:0] rnd);
    logic [31:0] w3;
    logic [31:0] t;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] n3;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon(rnd), 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = w3        ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign w_next_key = round_key(r_work, r_cnt);

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE, S_READY: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXPAND;
        end
      end
      S_EXPAND: begin
        w_step = 1'b1;
        if (r_cnt == 4'd9) begin
          w_last      = 1'b1;
          w_state_nxt = S_READY;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef KEYSCHED_ZEROIZE_EN
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      for (int k = 0; k < 11; k++) r_store[k] <= '0;
    end else if (w_accept) begin
      r_store[0] <= i_key_in;
      for (int k = 1; k < 11; k++) r_store[k] <= '0;
    end else if (w_step) begin
      r_store[r_cnt + 4'd1] <= w_next_key;
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (w_accept)    r_store[0] <= i_key_in;
    else if (w_step) r_store[r_cnt + 4'd1] <= w_next_key;
  end
`endif

  // Read gating uses pre-edge key_ready, so a read alongside a restart returns the old key.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_work     <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_rd_key   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_work <= i_key_in;
        r_cnt  <= '0;
      end else if (w_step) begin
        r_work <= w_next_key;
        r_cnt  <= w_last ? 4'd0 : r_cnt + 4'd1;
      end
      if (i_rd_en) begin
        if (o_key_ready && (i_rd_idx <= 4'd10)) begin
          r_rd_key   <= r_store[i_rd_idx];
          r_rd_valid <= 1'b1;
          r_rd_err   <= 1'b0;
        end else begin
          r_rd_key   <= '0;
          r_rd_valid <= 1'b0;
          r_rd_err   <= 1'b1;
        end
      end else begin
        r_rd_valid <= 1'b0;
        r_rd_err   <= 1'b0;
      end
    end
  end

  assign o_busy      = (r_state == S_EXPAND);
  assign o_key_ready = (r_state == S_READY);
  assign o_done      = r_done;
  assign o_rd_key    = r_rd_key;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_err    = r_rd_err;

endmodule
